pipe_stage_reg: RTL

Parametrised pipeline stage register with valid/ready handshake, hazard stall, synchronous flush with per-bit clear masking, and an optional skid entry. It generalises the fixed 32-bit enable/clear boundary registers (IF/ID, ID/EX, …) into one block instantiated at every stage boundary of the MIPS pipeline. It sits between a producer stage (`in_*`) and a consumer stage (`out_*`).

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/pipe_data_reg.sv | 23 ++
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary definitions: stage state encoding, MIPS NOP and
// per-boundary flush masks used by pipe_stage_reg.
package pipe_pkg;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  // sll $0,$0,0
  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Flush masks per boundary: instruction/control fields cleared, PC kept.
  localparam logic [63:0] IF_ID_CLR_MASK  = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] ID_EX_CLR_MASK  = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] EX_MEM_CLR_MASK = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] MEM_WB_CLR_MASK = 64'h0000_0000_0000_000F;

endpackage

// File: rtl/pipe_data_reg.sv
// Payload register with async active-low reset, load enable and a masked
// synchronous clear (clear wins over load).
module pipe_data_reg #(
  parameter int             W         = 64,
  parameter logic [W-1:0]   MASK      = '0,
  parameter logic [W-1:0]   CLR_VALUE = '0,
  parameter logic [W-1:0]   RST_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= RST_VALUE;
    else if (clr) q <= (q & ~MASK) | (CLR_VALUE & MASK);
    else if (ld)  q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with valid/ready, stall, masked flush.
// Define PIPE_STAGE_SKID_EN for a second (skid) entry that decouples in_ready from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] CLR_MASK  = IF_ID_CLR_MASK,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state_q, state_d;
  logic              acc, rel;
  logic              head_ld;
  logic [DATA_W-1:0] head_d;

  assign out_valid = (state_q != ST_EMPTY) & ~stall;
  assign occupancy = state_q;
  assign acc       = in_valid & in_ready;
  assign rel       = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_ld;
  logic              head_from_skid;
  logic [DATA_W-1:0] skid_q;

  assign in_ready = rst & ~stall & (state_q != ST_SKID);
  assign head_d   = head_from_skid ? skid_q : in_data;

  // Skid contents are meaningless once state leaves SKID; flush zeroes it anyway.
  pipe_data_reg #(
    .W(DATA_W), .MASK({DATA_W{1'b1}}), .CLR_VALUE(CLR_VALUE), .RST_VALUE(CLR_VALUE)
  ) u_skid (
    .clk(clk), .rst(rst), .ld(skid_ld), .clr(flush), .d(in_data), .q(skid_q)
  );
`else
  assign in_ready = rst & ~stall & ((state_q == ST_EMPTY) | out_ready);
  assign head_d   = in_data;
`endif

  pipe_data_reg #(
    .W(DATA_W), .MASK(CLR_MASK), .CLR_VALUE(CLR_VALUE), .RST_VALUE(CLR_VALUE)
  ) u_head (
    .clk(clk), .rst(rst), .ld(head_ld), .clr(flush), .d(head_d), .q(out_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_EMPTY;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    head_ld = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_ld        = 1'b0;
    head_from_skid = 1'b0;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (!stall) begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_FULL;
            head_ld = 1'b1;
          end
        end
        ST_FULL: begin
          if (acc && rel) begin
            head_ld = 1'b1;
          end else if (rel) begin
            state_d = ST_EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          end else if (acc) begin
            state_d = ST_SKID;
            skid_ld = 1'b1;
`endif
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: begin
          if (rel) begin
            state_d        = ST_FULL;
            head_ld        = 1'b1;
            head_from_skid = 1'b1;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

endmodule
